// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: widths,
// op encodings, instruction field positions and FSM state encoding.
package alu_pkg;

    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int INSTR_W  = 8;

    // ALU op-select encodings
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    // Instruction layout: [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt
    localparam int OP_LSB = 6;
    localparam int RD_LSB = 4;
    localparam int RS_LSB = 2;
    localparam int RT_LSB = 0;

    // Issue FSM state encoding
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] CAPT = 2'b10;

    // Value written back when a divide by zero is trapped
    localparam logic [DATA_W-1:0] DIVZERO_RESULT = 4'hF;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus the ALU operand/result bus. The slave side is
// the controller; the master side is the instruction source and the ALU.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic [1:0]           alu_arithmetic_mux;
    logic [DATA_W-1:0]    alu_rs;
    logic [DATA_W-1:0]    alu_rt;
    logic [DATA_W-1:0]    alu_result;

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_arithmetic_mux, alu_rs, alu_rt
    );

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_arithmetic_mux, alu_rs, alu_rt
    );

endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x DATA_W register file: three combinational read ports
// (rs, rt, peek) and one write port where the ALU writeback beats a
// direct load aimed at the same entry. Synchronous active-low clear.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [IDX_W-1:0]  rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [IDX_W-1:0]  peek_addr,
    output logic [DATA_W-1:0] peek_data
);

    logic [NUM_REGS*DATA_W-1:0] rf_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            // Per-entry update: clear on reset, writeback has priority over load
            always_ff @(posedge clk) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (wb_en && wb_addr == IDX_W'(gi)) begin
                    entry_reg <= wb_data;
                end else if (load_en && load_addr == IDX_W'(gi)) begin
                    entry_reg <= load_data;
                end
            end

            assign rf_flat[gi*DATA_W +: DATA_W] = entry_reg;
        end
    endgenerate

    assign rs_data   = rf_flat[rs_addr*DATA_W +: DATA_W];
    assign rt_data   = rf_flat[rt_addr*DATA_W +: DATA_W];
    assign peek_data = rf_flat[peek_addr*DATA_W +: DATA_W];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue and writeback controller for the 4-bit registered ALU.
// Accepts one instruction per 3 cycles (IDLE -> EXEC -> CAPT), drives the
// ALU with operands read from the local register file and writes the
// registered ALU result back to rd, pulsing done.
// Optional build macro ALU_DIVZERO_TRAP_EN: a DIV whose rt reads zero at
// issue writes DIVZERO_RESULT instead of the ALU result and pulses div_zero.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.slave   bus,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  peek_addr,
    output logic [DATA_W-1:0] peek_data,
    output logic              done,
    output logic              busy,
    output logic              div_zero
);

    logic [1:0]        state_reg;
    logic [IDX_W-1:0]  rd_reg;
    logic [1:0]        mux_reg;
    logic [DATA_W-1:0] rs_reg;
    logic [DATA_W-1:0] rt_reg;
    logic              done_reg;

    logic [1:0]        op;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rs_idx;
    logic [IDX_W-1:0]  rt_idx;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              handshake;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;

    assign op     = bus.instr[OP_LSB +: 2];
    assign rd_idx = bus.instr[RD_LSB +: IDX_W];
    assign rs_idx = bus.instr[RS_LSB +: IDX_W];
    assign rt_idx = bus.instr[RT_LSB +: IDX_W];

    assign bus.instr_ready = (state_reg == IDLE) && reset;
    assign handshake       = bus.instr_valid && bus.instr_ready;
    assign busy            = (state_reg != IDLE);
    assign done            = done_reg;

    assign bus.alu_arithmetic_mux = mux_reg;
    assign bus.alu_rs             = rs_reg;
    assign bus.alu_rt             = rt_reg;

    // Writeback happens on the edge that closes CAPT
    assign wb_en = (state_reg == CAPT);

    alu_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wb_en     (wb_en),
        .wb_addr   (rd_reg),
        .wb_data   (wb_data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rs_addr   (rs_idx),
        .rs_data   (rs_data),
        .rt_addr   (rt_idx),
        .rt_data   (rt_data),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    // Issue FSM: latch operands on accept, wait for the ALU, then retire
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            rd_reg    <= '0;
            mux_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        rd_reg    <= rd_idx;
                        mux_reg   <= op;
                        rs_reg    <= rs_data;
                        rt_reg    <= rt_data;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    state_reg <= CAPT;
                end
                CAPT: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_DIVZERO_TRAP_EN
    logic dz_pending_reg;
    logic div_zero_reg;

    // Flag a divide by zero at issue time and report it alongside done
    always_ff @(posedge clk) begin
        if (!reset) begin
            dz_pending_reg <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            div_zero_reg <= 1'b0;
            if (handshake) begin
                dz_pending_reg <= (op == DIV) && (rt_data == '0);
            end
            if (state_reg == CAPT) begin
                div_zero_reg <= dz_pending_reg;
            end
        end
    end

    assign wb_data  = dz_pending_reg ? DIVZERO_RESULT : bus.alu_result;
    assign div_zero = div_zero_reg;
`else
    assign wb_data  = bus.alu_result;
    assign div_zero = 1'b0;
`endif

endmodule
